// File: rtl/rot_cordic_pkg.sv
// Shared constants for the CORDIC rotator lanes: default data width and the
// shift/sign table of the gain-compensation multiplier K = 0.607421875.
package rot_cordic_pkg;

    // Default lane data width (two's complement).
    localparam int WIDTH_DEF = 18;

    // K = 2^-1 + 2^-3 - 2^-6 - 2^-9, expressed as four shifted terms.
    localparam int GAIN_TERMS = 4;
    localparam int GAIN_SHIFT [0:GAIN_TERMS-1] = '{1, 3, 6, 9};

    // Bit i set means term i is subtracted rather than added.
    localparam logic [GAIN_TERMS-1:0] GAIN_NEG = 4'b1100;

endpackage

// File: rtl/rot_cordic_gain_scale.sv
// Combinational multiply by the CORDIC gain constant K = 0.607421875 using
// arithmetic (flooring) right shifts. Terms are summed at WIDTH bits; since
// K < 1 the magnitude of the output never exceeds the input, so no
// saturation is needed here.
module rot_cordic_gain_scale
    import rot_cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic signed [WIDTH-1:0] data_s;
    logic signed [WIDTH-1:0] term_s;
    logic signed [WIDTH-1:0] acc_s;

    assign data_s = $signed(data_in);

    // Accumulate the signed shifted terms of K.
    always_comb begin
        acc_s  = '0;
        term_s = '0;
        for (int i = 0; i < GAIN_TERMS; i++) begin
            term_s = data_s >>> GAIN_SHIFT[i];
            if (GAIN_NEG[i]) begin
                acc_s = acc_s - term_s;
            end else begin
                acc_s = acc_s + term_s;
            end
        end
    end

    assign data_out = acc_s;

endmodule

// File: rtl/rot_cordic_lane.sv
// One coordinate lane of the iterative CORDIC rotator: clock-enabled state
// register (init load or feedback), add/sub against an external operand, and
// a gain-compensation scaler on the add/sub result.
// Optional build macro ROT_CORDIC_SAT_EN: the add/sub result saturates to the
// signed range instead of wrapping; the saturated value feeds both the state
// register and the scaler.
module rot_cordic_lane
    import rot_cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             sel,
    input  logic             add,
    input  logic [WIDTH-1:0] init_in,
    input  logic [WIDTH-1:0] operand_in,
    output logic [WIDTH-1:0] state_out,
    output logic             sign_out,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] scaled_out
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] next_state_s;

    // Modular add or subtract of the operand against the current state.
    always_comb begin
        sum_s = '0;
        if (add) begin
            sum_s = state_r + operand_in;
        end else begin
            sum_s = state_r - operand_in;
        end
    end

`ifdef ROT_CORDIC_SAT_EN
    logic ovf_pos_s;
    logic ovf_neg_s;

    // Clamp the result to the signed range when the add/sub overflowed.
    always_comb begin
        ovf_pos_s = 1'b0;
        ovf_neg_s = 1'b0;
        result_s  = sum_s;
        if (add) begin
            ovf_pos_s = !state_r[WIDTH-1] && !operand_in[WIDTH-1] &&  sum_s[WIDTH-1];
            ovf_neg_s =  state_r[WIDTH-1] &&  operand_in[WIDTH-1] && !sum_s[WIDTH-1];
        end else begin
            ovf_pos_s = !state_r[WIDTH-1] &&  operand_in[WIDTH-1] &&  sum_s[WIDTH-1];
            ovf_neg_s =  state_r[WIDTH-1] && !operand_in[WIDTH-1] && !sum_s[WIDTH-1];
        end
        if (ovf_pos_s) begin
            result_s = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (ovf_neg_s) begin
            result_s = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            result_s = sum_s;
        end
    end
`else
    // Wrap modulo 2^WIDTH: the raw sum is the result.
    always_comb begin
        result_s = sum_s;
    end
`endif

    // Select the value the state register loads on an enabled edge.
    always_comb begin
        next_state_s = state_r;
        if (sel) begin
            next_state_s = result_s;
        end else begin
            next_state_s = init_in;
        end
    end

    // State register: async clear, loads only when ce is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '0;
        end else if (ce) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    rot_cordic_gain_scale #(
        .WIDTH (WIDTH)
    ) u_gain_scale (
        .data_in  (result_s),
        .data_out (scaled_out)
    );

    assign state_out  = state_r;
    assign sign_out   = state_r[WIDTH-1];
    assign result_out = result_s;

endmodule

// File: tb/tb_rot_cordic_lane.sv
// Directed self-checking bench for rot_cordic_lane (WIDTH = 18).
// Expected values are hand-computed; ROT_CORDIC_SAT_EN selects the
// saturating expectations for the overflow cases.
module tb_rot_cordic_lane;

    localparam int W = 18;

    logic         clk;
    logic         rst_n;
    logic         ce;
    logic         sel;
    logic         add;
    logic [W-1:0] init_in;
    logic [W-1:0] operand_in;
    logic [W-1:0] state_out;
    logic         sign_out;
    logic [W-1:0] result_out;
    logic [W-1:0] scaled_out;

    int tests_run;
    int tests_failed;

    rot_cordic_lane #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .sel        (sel),
        .add        (add),
        .init_in    (init_in),
        .operand_in (operand_in),
        .state_out  (state_out),
        .sign_out   (sign_out),
        .result_out (result_out),
        .scaled_out (scaled_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load a value into the state with sel=0, leaving ce low afterwards.
    task automatic load_state(input logic [W-1:0] v);
        ce = 1'b1; sel = 1'b0; init_in = v;
        tick();
        ce = 1'b0;
    endtask

    task automatic test_reset;
        load_state(18'd500);
        add = 1'b1; operand_in = 18'd7;
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (state_out !== 18'd0) begin
            $display("FAIL reset_state: got %0d expected 0", state_out); tests_failed++;
        end
        tests_run++;
        if (sign_out !== 1'b0) begin
            $display("FAIL reset_sign: got %0b expected 0", sign_out); tests_failed++;
        end
        tests_run++;
        if (result_out !== 18'd7) begin
            $display("FAIL reset_result: got %0d expected 7", result_out); tests_failed++;
        end
        tests_run++;
        if (scaled_out !== 18'd3) begin
            $display("FAIL reset_scaled: got %0d expected 3", scaled_out); tests_failed++;
        end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_add;
        ce = 1'b1; sel = 1'b0; init_in = 18'd1000;
        tick();
        tests_run++;
        if (state_out !== 18'd1000) begin
            $display("FAIL load_state: got %0d expected 1000", state_out); tests_failed++;
        end
        sel = 1'b1; add = 1'b1; operand_in = 18'd200;
        #1;
        tests_run++;
        if (result_out !== 18'd1200) begin
            $display("FAIL add_result: got %0d expected 1200", result_out); tests_failed++;
        end
        tests_run++;
        if (scaled_out !== 18'd730) begin
            $display("FAIL add_scaled: got %0d expected 730", scaled_out); tests_failed++;
        end
        tick();
        tests_run++;
        if (state_out !== 18'd1200) begin
            $display("FAIL add_state: got %0d expected 1200", state_out); tests_failed++;
        end
        ce = 1'b0;
    endtask

    task automatic test_sub_negative;
        ce = 1'b1; sel = 1'b1; add = 1'b0; operand_in = 18'd2000;
        #1;
        tests_run++;
        if (result_out !== 18'd261344) begin
            $display("FAIL sub_result: got %0d expected 261344", result_out); tests_failed++;
        end
        // -800 * K: -400 - 100 + 13 + 2 = -485
        tests_run++;
        if (scaled_out !== 18'(-485)) begin
            $display("FAIL sub_scaled: got %0d expected %0d", scaled_out, 18'(-485)); tests_failed++;
        end
        tick();
        tests_run++;
        if (state_out !== 18'd261344) begin
            $display("FAIL sub_state: got %0d expected 261344", state_out); tests_failed++;
        end
        tests_run++;
        if (sign_out !== 1'b1) begin
            $display("FAIL sub_sign: got %0b expected 1", sign_out); tests_failed++;
        end
        ce = 1'b0;
    endtask

    task automatic test_ce_hold;
        ce = 1'b0; sel = 1'b1; add = 1'b1; operand_in = 18'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (state_out !== 18'(-800)) begin
                $display("FAIL hold_state[%0d]: got %0d expected %0d", i, state_out, 18'(-800)); tests_failed++;
            end
            tests_run++;
            if (result_out !== 18'(-750)) begin
                $display("FAIL hold_result[%0d]: got %0d expected %0d", i, result_out, 18'(-750)); tests_failed++;
            end
        end
    endtask

    task automatic test_scaling;
        load_state(18'd4096);
        add = 1'b1; operand_in = 18'd0;
        #1;
        tests_run++;
        if (scaled_out !== 18'd2488) begin
            $display("FAIL scale_pos: got %0d expected 2488", scaled_out); tests_failed++;
        end
        load_state(18'(-4096));
        #1;
        tests_run++;
        if (scaled_out !== 18'(-2488)) begin
            $display("FAIL scale_neg: got %0d expected %0d", scaled_out, 18'(-2488)); tests_failed++;
        end
    endtask

    task automatic test_overflow;
        logic [W-1:0] exp_v;
`ifdef ROT_CORDIC_SAT_EN
        exp_v = 18'd131071;
`else
        exp_v = 18'd131072;
`endif
        load_state(18'd131071);
        add = 1'b1; operand_in = 18'd1;
        #1;
        tests_run++;
        if (result_out !== exp_v) begin
            $display("FAIL ovf_result: got %0d expected %0d", result_out, exp_v); tests_failed++;
        end
        ce = 1'b1; sel = 1'b1;
        tick();
        ce = 1'b0;
        tests_run++;
        if (state_out !== exp_v) begin
            $display("FAIL ovf_state: got %0d expected %0d", state_out, exp_v); tests_failed++;
        end
        tests_run++;
        if (sign_out !== exp_v[W-1]) begin
            $display("FAIL ovf_sign: got %0b expected %0b", sign_out, exp_v[W-1]); tests_failed++;
        end
    endtask

    task automatic test_min_operand;
        logic [W-1:0] exp_v;
`ifdef ROT_CORDIC_SAT_EN
        exp_v = 18'd131071;
`else
        exp_v = 18'd131072;
`endif
        load_state(18'd0);
        add = 1'b0; operand_in = 18'd131072;
        #1;
        tests_run++;
        if (result_out !== exp_v) begin
            $display("FAIL minop_result: got %0d expected %0d", result_out, exp_v); tests_failed++;
        end
    endtask

    task automatic test_reset_restart;
        load_state(18'd300);
        ce = 1'b1; sel = 1'b1; add = 1'b1; operand_in = 18'd10;
        tick();
        ce = 1'b0;
        tests_run++;
        if (state_out !== 18'd310) begin
            $display("FAIL iter_state: got %0d expected 310", state_out); tests_failed++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (state_out !== 18'd0) begin
            $display("FAIL midreset_state: got %0d expected 0", state_out); tests_failed++;
        end
        #2;
        rst_n = 1'b1;
        // sel=1 with ce=0 must not disturb the cleared state
        sel = 1'b1;
        tick();
        tests_run++;
        if (state_out !== 18'd0) begin
            $display("FAIL postreset_hold: got %0d expected 0", state_out); tests_failed++;
        end
        load_state(18'd77);
        tests_run++;
        if (state_out !== 18'd77) begin
            $display("FAIL restart_state: got %0d expected 77", state_out); tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        ce         = 1'b0;
        sel        = 1'b0;
        add        = 1'b0;
        init_in    = '0;
        operand_in = '0;
        #12;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (state_out !== 18'd0) begin
            $display("FAIL initial_state: got %0d expected 0", state_out); tests_failed++;
        end
        test_reset();
        test_load_add();
        test_sub_negative();
        test_ce_hold();
        test_scaling();
        test_overflow();
        test_min_operand();
        test_reset_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rot_cordic_lane.md
Name: rot_cordic_lane

Overview:
- One coordinate lane of the iterative (time-multiplexed) CORDIC rotator in the QAM-16 receiver.
- Contains three parts:
  - a clock-enabled state register that loads either an initial value or its own feedback;
  - a combinational adder/subtractor that combines the state with an externally supplied operand (the shifted cross term or the arctan constant);
  - a shift-add multiplier by the CORDIC gain-compensation constant K≈0.6074.
- Instantiated once per x/y/z lane by the CORDIC top level.

Parameters:
- WIDTH, 18: data width of state, operand and outputs; two's complement.

Ports:
- clk, input, 1: the block's single clock; rising-edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- ce, input, 1: clock enable for the state register.
- sel, input, 1: 0 = load init_in, 1 = load feedback result.
- add, input, 1: 1 = result is state + operand; 0 = result is state − operand.
- init_in, input, WIDTH: initial value loaded when sel=0.
- operand_in, input, WIDTH: second addend/subtrahend.
- state_out, output, WIDTH: registered state.
- sign_out, output, 1: state_out[WIDTH-1].
- result_out, output, WIDTH: combinational add/sub result.
- scaled_out, output, WIDTH: result_out × K, combinational.

Behaviour:
- Reset:
  - While rst_n=0, state is cleared to 0 immediately, independent of clk; sign_out=0.
  - result_out and scaled_out follow combinationally from state=0.
- Register update, at rising clk with rst_n=1:
  - if ce=1: state <= sel ? result_out : init_in;
  - if ce=0: state holds.
- Latency: result_out and scaled_out are 0-cycle combinational functions of state, operand_in and add. The state reflects an update 1 cycle after the enabling edge.
- Add/sub:
  - result_out = add ? state+operand_in : state−operand_in.
  - Computed at WIDTH bits, signed.
  - Overflow wraps modulo 2^WIDTH (default build).
- Gain scaling:
  - scaled_out = (r>>>1) + (r>>>3) − (r>>>6) − (r>>>9), with r = result_out.
  - Each term is an arithmetic right shift (floor). Terms are summed at WIDTH bits with wrap.
  - Effective K = 0.607421875.
- Boundaries:
  - sel is sampled only when ce=1.
  - Asserting reset mid-iteration clears the state; the next ce with sel=0 restarts the iteration.
  - operand_in = −2^(WIDTH-1) with add=0 wraps (no special case).
- sign_out always equals the state MSB, including directly after reset and after a wrap.

Optional Feature:
- Macro: ROT_CORDIC_SAT_EN.
- Defined: result_out saturates instead of wrapping.
  - Positive overflow gives 2^(WIDTH-1)−1.
  - Negative overflow gives −2^(WIDTH-1).
  - The saturated value also feeds the register and the scaler.
- Undefined: modular wrap as described above.
- The scaler never saturates; its |output| is less than |input|, so no overflow is possible.

Decomposition:
- Shared package rot_cordic_pkg holds:
  - default WIDTH (18);
  - gain shift constants (1, 3, 6, 9) and their signs (+, +, −, −).
- One natural sub-module: rot_cordic_gain_scale, the pure combinational K multiplier with parameter WIDTH. It is reused by the x and y lanes.
- The register mux and add/sub stay inline in rot_cordic_lane.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 asynchronously mid-cycle, with state previously 500, add=1, operand_in=7.
  - Response: state_out=0 and sign_out=0 at once, before the next clk edge; result_out=7; scaled_out=3.
- Load then add:
  - Stimulus: ce=1, sel=0, init_in=1000, one edge; then sel=1, add=1, operand_in=200.
  - Response: after the first edge state=1000; then result_out=1200 and scaled_out=730 combinationally; after the next edge state_out=1200.
- Subtract to negative:
  - Stimulus: from state=1200, add=0, operand_in=2000, one edge.
  - Response: result_out=−800 (262144−800=261344 unsigned) before the edge; state_out=−800 and sign_out=1 after the edge.
- Clock-enable hold:
  - Stimulus: ce=0 for 3 edges with sel=1, add=1, operand_in=50.
  - Response: state_out is unchanged; result_out stays state+50.
- Scaling symmetry:
  - Stimulus: state=4096, add=1, operand_in=0.
  - Response: scaled_out=2488.
  - Stimulus: state=−4096, same add and operand.
  - Response: scaled_out=−2488.
- Overflow:
  - Stimulus: state=131071, add=1, operand_in=1.
  - Response: result_out=−131072 in the default build; result_out=131071 when ROT_CORDIC_SAT_EN is defined.
